// File: rtl/hero_motion_ctrl_pkg.sv
// Shared encodings and widths for the hero movement logic.
package hero_pkg;

  localparam int XW = 10;
  localparam int HW = 8;
  localparam int TW = 16;

  typedef enum logic [1:0] {
    PH_GROUND = 2'd0,
    PH_RISE   = 2'd1,
    PH_APEX   = 2'd2,
    PH_FALL   = 2'd3
  } phase_e;

endpackage

// File: rtl/hero_motion_ctrl_step_timer.sv
// Free-running cycle counter that emits a one-cycle step on wrap.
module step_timer
  import hero_pkg::*;
#(
  parameter int W = TW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         step
);

  logic [W-1:0] cnt_q, cnt_d;

  // step ignores clr so the owner may derive clr from step
  always_comb begin
    step  = en && (cnt_q >= last);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= last) cnt_d = '0;
      else               cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hero_motion_ctrl.sv
// Hero position, height, facing and jump phase, stepped on the 1 ms tick.
module hero_motion_ctrl
  import hero_pkg::*;
#(
  parameter int X_START      = 32,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 600,
  parameter int X_STEP_MS    = 5,
  parameter int JUMP_HEIGHT  = 64,
  parameter int RISE_STEP_MS = 2,
  parameter int FALL_STEP_MS = 2,
  parameter int APEX_HOLD_MS = 40
) (
  input  logic          clk_1ms,
  input  logic          rst,
  input  logic          left,
  input  logic          right,
  input  logic          jump,
  output logic [XW-1:0] hero_x,
  output logic [HW-1:0] hero_h,
  output logic          facing_left,
  output logic [1:0]    phase,
  output logic          landed
);

  localparam logic [XW-1:0] X_START_V = XW'(X_START);
  localparam logic [XW-1:0] X_MIN_V   = XW'(X_MIN);
  localparam logic [XW-1:0] X_MAX_V   = XW'(X_MAX);
  localparam logic [HW-1:0] H_TOP_M1  = HW'(JUMP_HEIGHT - 1);
  localparam logic [TW-1:0] X_LAST    = TW'(X_STEP_MS - 1);
  localparam logic [TW-1:0] R_LAST    = TW'(RISE_STEP_MS - 1);
  localparam logic [TW-1:0] A_LAST    = TW'(APEX_HOLD_MS - 1);
  localparam logic [TW-1:0] F_LAST    = TW'(FALL_STEP_MS - 1);

  logic [XW-1:0] hero_x_q, hero_x_d;
  logic [HW-1:0] hero_h_q, hero_h_d;
  logic          facing_q, facing_d;
  phase_e        phase_q, phase_d;
  logic          landed_q, landed_d;
  logic          jump_prev_q;

  logic          valid_dir, x_step, jump_edge;
  logic          v_en, v_clr, v_step;
  logic [TW-1:0] v_last;

  assign valid_dir = left ^ right;
  assign jump_edge = jump & ~jump_prev_q;

  step_timer #(.W(TW)) u_x_timer (
    .clk  (clk_1ms),
    .rst  (rst),
    .en   (valid_dir),
    .clr  (~valid_dir),
    .last (X_LAST),
    .step (x_step)
  );

  always_comb begin
    hero_x_d = hero_x_q;
    facing_d = facing_q;
    if (valid_dir) facing_d = left;
    if (x_step) begin
      if (right && hero_x_q < X_MAX_V)
        hero_x_d = hero_x_q + XW'(1);
      else if (left && hero_x_q > X_MIN_V)
        hero_x_d = hero_x_q - XW'(1);
    end
  end

  // one counter serves every airborne phase with its own period
  always_comb begin
    v_last = R_LAST;
    unique case (phase_q)
      PH_APEX: v_last = A_LAST;
      PH_FALL: v_last = F_LAST;
      default: v_last = R_LAST;
    endcase
  end

  assign v_en  = (phase_q != PH_GROUND);
  assign v_clr = (phase_q == PH_GROUND) || (phase_d != phase_q);

  step_timer #(.W(TW)) u_v_timer (
    .clk  (clk_1ms),
    .rst  (rst),
    .en   (v_en),
    .clr  (v_clr),
    .last (v_last),
    .step (v_step)
  );

  always_comb begin
    phase_d  = phase_q;
    hero_h_d = hero_h_q;
    landed_d = 1'b0;
    unique case (phase_q)
      PH_GROUND: begin
        if (jump_edge) phase_d = PH_RISE;
      end
      PH_RISE: begin
        if (!jump) begin
          phase_d = PH_FALL;
        end else if (v_step) begin
          hero_h_d = hero_h_q + HW'(1);
          if (hero_h_q == H_TOP_M1) phase_d = PH_APEX;
        end
      end
      PH_APEX: begin
        if (v_step) phase_d = PH_FALL;
      end
      PH_FALL: begin
        if (hero_h_q == '0) begin
          phase_d  = PH_GROUND;
          landed_d = 1'b1;
        end else if (v_step) begin
          hero_h_d = hero_h_q - HW'(1);
          if (hero_h_q == HW'(1)) begin
            phase_d  = PH_GROUND;
            landed_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_1ms or posedge rst) begin
    if (rst) begin
      hero_x_q    <= X_START_V;
      hero_h_q    <= '0;
      facing_q    <= 1'b0;
      phase_q     <= PH_GROUND;
      landed_q    <= 1'b0;
      jump_prev_q <= 1'b1;
    end else begin
      hero_x_q    <= hero_x_d;
      hero_h_q    <= hero_h_d;
      facing_q    <= facing_d;
      phase_q     <= phase_d;
      landed_q    <= landed_d;
      jump_prev_q <= jump;
    end
  end

  assign hero_x      = hero_x_q;
  assign hero_h      = hero_h_q;
  assign facing_left = facing_q;
  assign phase       = phase_q;
  assign landed      = landed_q;

endmodule

// File: tb/tb_hero_motion_ctrl.sv
// Directed checks of hero_motion_ctrl with hand-derived timelines.
module tb_hero_motion_ctrl;

  logic       clk_1ms = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       jump = 1'b0;
  logic [9:0] hero_x;
  logic [7:0] hero_h;
  logic       facing_left;
  logic [1:0] phase;
  logic       landed;

  int errors = 0;
  int checks = 0;

  always #5 clk_1ms = ~clk_1ms;

  hero_motion_ctrl dut (
    .clk_1ms     (clk_1ms),
    .rst         (rst),
    .left        (left),
    .right       (right),
    .jump        (jump),
    .hero_x      (hero_x),
    .hero_h      (hero_h),
    .facing_left (facing_left),
    .phase       (phase),
    .landed      (landed)
  );

  // expected {phase, h, landed} c cycles after RISE entry, full jump
  function automatic logic [10:0] full_exp(input int c);
    if (c < 128)      return {2'd1, 8'(c / 2), 1'b0};
    else if (c < 168) return {2'd2, 8'd64, 1'b0};
    else if (c < 296) return {2'd3, 8'(64 - (c - 168) / 2), 1'b0};
    else if (c == 296) return {2'd0, 8'd0, 1'b1};
    else              return {2'd0, 8'd0, 1'b0};
  endfunction

  task automatic do_reset(input logic jlvl);
    @(negedge clk_1ms);
    rst = 1'b1; left = 1'b0; right = 1'b0; jump = jlvl;
    repeat (2) @(negedge clk_1ms);
    rst = 1'b0;
  endtask

  // leaves the bench at the negedge just after RISE entry
  task automatic start_jump();
    jump = 1'b0;
    repeat (2) @(negedge clk_1ms);
    jump = 1'b1;
    @(negedge clk_1ms);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({hero_x, hero_h, facing_left, phase, landed} !==
        {10'd32, 8'd0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: x=%0d h=%0d f=%b ph=%0d l=%b, want 32 0 0 0 0",
               hero_x, hero_h, facing_left, phase, landed);
    end
  endtask

  task automatic test_move_right();
    logic [9:0] ex;
    do_reset(1'b0);
    right = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_1ms);
      ex = 10'(32 + (i + 1) / 5);
      checks++;
      if (hero_x !== ex || facing_left !== 1'b0) begin
        errors++;
        $display("FAIL right[%0d]: x=%0d f=%b, want %0d 0",
                 i, hero_x, facing_left, ex);
      end
    end
    left = 1'b1;
    repeat (20) @(negedge clk_1ms);
    checks++;
    if (hero_x !== 10'd42 || facing_left !== 1'b0) begin
      errors++;
      $display("FAIL both: x=%0d f=%b, want 42 0", hero_x, facing_left);
    end
    left = 1'b0; right = 1'b0;
  endtask

  task automatic test_left_clamp();
    int e;
    do_reset(1'b0);
    left = 1'b1;
    for (int i = 0; i < 180; i++) begin
      @(negedge clk_1ms);
      e = 32 - (i + 1) / 5;
      if (e < 0) e = 0;
      if (i >= 148) begin
        checks++;
        if (hero_x !== 10'(e) || facing_left !== 1'b1) begin
          errors++;
          $display("FAIL left[%0d]: x=%0d f=%b, want %0d 1",
                   i, hero_x, facing_left, e);
        end
      end
    end
    left = 1'b0;
  endtask

  task automatic test_right_clamp();
    int e;
    do_reset(1'b0);
    right = 1'b1;
    for (int i = 0; i < 2900; i++) begin
      @(negedge clk_1ms);
      e = 32 + (i + 1) / 5;
      if (e > 600) e = 600;
      if (i >= 2835) begin
        checks++;
        if (hero_x !== 10'(e)) begin
          errors++;
          $display("FAIL rclamp[%0d]: x=%0d, want %0d", i, hero_x, e);
        end
      end
    end
    right = 1'b0;
  endtask

  task automatic test_full_jump(input logic repulse);
    logic [10:0] ex;
    do_reset(1'b0);
    start_jump();
    for (int c = 0; c < 400; c++) begin
      ex = full_exp(c);
      checks++;
      if ({phase, hero_h, landed} !== ex) begin
        errors++;
        $display("FAIL jump%0d[c=%0d]: ph=%0d h=%0d l=%b, want %0d %0d %b",
                 repulse, c, phase, hero_h, landed, ex[10:9], ex[8:1], ex[0]);
      end
      if (repulse) begin
        if (c == 140 || c == 200) jump = 1'b0;
        if (c == 145 || c == 205) jump = 1'b1;
      end
      @(negedge clk_1ms);
    end
    jump = 1'b0;
  endtask

  task automatic test_short_jump();
    logic [10:0] ex;
    do_reset(1'b0);
    start_jump();
    for (int c = 0; c < 60; c++) begin
      if (c <= 20)      ex = {2'd1, 8'(c / 2), 1'b0};
      else if (c < 41)  ex = {2'd3, 8'(10 - (c - 21) / 2), 1'b0};
      else if (c == 41) ex = {2'd0, 8'd0, 1'b1};
      else              ex = {2'd0, 8'd0, 1'b0};
      checks++;
      if ({phase, hero_h, landed} !== ex) begin
        errors++;
        $display("FAIL short[c=%0d]: ph=%0d h=%0d l=%b, want %0d %0d %b",
                 c, phase, hero_h, landed, ex[10:9], ex[8:1], ex[0]);
      end
      if (c == 20) jump = 1'b0;
      @(negedge clk_1ms);
    end
  endtask

  task automatic test_zero_release();
    do_reset(1'b0);
    start_jump();
    jump = 1'b0;
    @(negedge clk_1ms);
    checks++;
    if ({phase, hero_h, landed} !== {2'd3, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL zrel_fall: ph=%0d h=%0d l=%b, want 3 0 0",
               phase, hero_h, landed);
    end
    @(negedge clk_1ms);
    checks++;
    if ({phase, hero_h, landed} !== {2'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL zrel_land: ph=%0d h=%0d l=%b, want 0 0 1",
               phase, hero_h, landed);
    end
  endtask

  task automatic test_jump_through_reset();
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1ms);
      checks++;
      if (phase !== 2'd0 || hero_h !== 8'd0) begin
        errors++;
        $display("FAIL held_rst[%0d]: ph=%0d h=%0d, want 0 0",
                 i, phase, hero_h);
      end
    end
    jump = 1'b0;
  endtask

  task automatic test_reset_mid_fall();
    do_reset(1'b0);
    left = 1'b1;
    start_jump();
    repeat (200) @(negedge clk_1ms);
    checks++;
    if (phase !== 2'd3 || facing_left !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: ph=%0d f=%b, want 3 1", phase, facing_left);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hero_x, hero_h, facing_left, phase, landed} !==
        {10'd32, 8'd0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_rst: x=%0d h=%0d f=%b ph=%0d l=%b, want 32 0 0 0 0",
               hero_x, hero_h, facing_left, phase, landed);
    end
    @(negedge clk_1ms);
    rst = 1'b0; left = 1'b0; jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_left_clamp();
    test_right_clamp();
    test_full_jump(1'b0);
    test_full_jump(1'b1);
    test_short_jump();
    test_zero_release();
    test_jump_through_reset();
    test_reset_mid_fall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hero_motion_ctrl.md
# hero_motion_ctrl

Sequences the hero's movement from the debounced button levels `left`, `right` and `jump` produced by the input block. It holds the hero's horizontal position, height above ground, facing direction and jump phase, stepping all of them on the 1 ms game clock. The renderer and collision logic read its registered outputs.

## Interface
Parameters:
- X_START, 32: hero_x value after reset
- X_MIN, 0: left clamp for hero_x
- X_MAX, 600: right clamp for hero_x
- X_STEP_MS, 5: clk_1ms cycles per 1-pixel horizontal step
- JUMP_HEIGHT, 64: apex height in pixels (1..255)
- RISE_STEP_MS, 2: cycles per +1 height step
- FALL_STEP_MS, 2: cycles per -1 height step
- APEX_HOLD_MS, 40: cycles spent at apex

Ports:
- clk_1ms  in  1  sole clock, 1 kHz game tick
- rst  in  1  reset, asynchronous, active-high
- left  in  1  debounced level, 1 = held
- right  in  1  debounced level, 1 = held
- jump  in  1  debounced level, 1 = held
- hero_x  out  10  horizontal pixel position
- hero_h  out  8  height above ground, 0 = standing
- facing_left  out  1  1 = facing left
- phase  out  2  jump phase: GROUND=0, RISE=1, APEX=2, FALL=3
- landed  out  1  one-cycle pulse on return to GROUND

## Operation
- All outputs are registered. Reset values: hero_x=X_START, hero_h=0, facing_left=0, phase=GROUND, landed=0. The jump edge register resets to 1.
- Horizontal motion:
  - Direction is valid when exactly one of left/right is high.
  - With a valid direction, the horizontal counter increments each cycle. When it reaches X_STEP_MS-1, it clears and hero_x moves one pixel in that direction.
  - hero_x saturates at X_MIN and X_MAX. At a bound the counter keeps running but hero_x holds.
  - With no valid direction (neither button, or both), the counter clears and hero_x holds.
  - facing_left updates on any cycle with a valid direction. It holds otherwise.
  - Horizontal motion is independent of phase, so the hero steers in the air.
- Jump start: a jump rising edge (jump=1, previous=0) starts a jump only in GROUND. Edges in any other phase are ignored. A jump held through reset or through a landing does not start a jump.
- Vertical FSM (one shared vertical counter, cleared on every phase change):
  - GROUND: on a jump edge, go to RISE.
  - RISE: every RISE_STEP_MS cycles, hero_h+1. On the step that makes hero_h==JUMP_HEIGHT, go to APEX.
    - If jump is low in RISE, go to FALL that cycle and freeze hero_h. This gives a variable jump height.
  - APEX: hold hero_h. After APEX_HOLD_MS cycles, go to FALL.
  - FALL: every FALL_STEP_MS cycles, hero_h-1. On the step that makes hero_h==0, go to GROUND and assert landed for that single cycle.
- Release with hero_h==0 (jump released on the cycle RISE was entered): FALL is entered and immediately returns to GROUND on its first check, with landed pulsed.
- Asserting rst mid-operation forces all reset values immediately. Any in-progress jump is discarded.

## Timing
- Horizontal latency: the first pixel step occurs X_STEP_MS cycles after the first valid-direction cycle. Subsequent steps come every X_STEP_MS cycles.
- The jump edge at cycle T gives phase=RISE at T+1.
- hero_h reaches k at T+1+k·RISE_STEP_MS.
- Full jump with defaults:
  - APEX entered 128 cycles after RISE entry.
  - FALL entered 40 cycles after that.
  - landed asserted and phase=GROUND 128 cycles after FALL entry, i.e. 296 cycles after RISE entry.
- landed is high for exactly one cycle.

## Structure
- Package hero_pkg holds:
  - phase encoding constants (GROUND/RISE/APEX/FALL)
  - the hero_x width (10) and hero_h width (8)
- Sub-module step_timer, instantiated twice (horizontal and vertical):
  - parameterised cycle count
  - enable and clear inputs
  - one-cycle step output when the count wraps
- The top level holds the jump edge register, the phase FSM, the position/height registers and their clamps.

## Test plan
- Reset, then hold right for 50 cycles → hero_x steps 32→42, one step every 5 cycles, facing_left=0. Then hold both buttons for 20 cycles → hero_x stays 42.
- Hold left from hero_x=2 for 30 cycles → hero_x reaches 0 at cycle 10 and stays 0; facing_left=1.
- One jump pulse, held 400 cycles → hero_h peaks at 64. APEX lasts 40 cycles. landed pulses once, 296 cycles after RISE entry, with hero_h=0. No second jump while jump stays high.
- Press jump and release after 20 cycles → hero_h peaks at 10, FALL follows immediately, landed comes 20 cycles after FALL entry.
- Re-pulse jump during APEX and during FALL → ignored; phase sequence unchanged.
- Jump held across rst deassertion → no jump. Assert rst mid-FALL → outputs return to reset values asynchronously.
